// File: rtl/com_divide_scheduler_pkg.sv
// Shared types and bounds for the centre-of-mass divide scheduler.
// Imported by the interface, the clamp and the scheduler top.
package com_divide_scheduler_pkg;

  localparam int TOT_W  = 35;
  localparam int MASS_W = 26;
  localparam int CEN_W  = 10;
  localparam int CNT_W  = 8;

  localparam int DEF_DIV_LATENCY = 4;
  localparam int DEF_MIN_MASS    = 64;
  localparam int DEF_X_MAX       = 639;
  localparam int DEF_Y_MAX       = 479;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_X,
    S_WAIT_X,
    S_ISSUE_Y,
    S_WAIT_Y
  } state_e;

  function automatic logic [CEN_W-1:0] mid_of(int bound);
    return CEN_W'(bound / 2);
  endfunction

endpackage

// File: rtl/com_divide_scheduler_if.sv
// Bus to the shared fixed-latency divider.
// master = scheduler side, slave = divider side.
interface com_divide_scheduler_if;
  import com_divide_scheduler_pkg::*;

  logic              div_rfd;
  logic              div_nd;
  logic [TOT_W-1:0]  div_dividend;
  logic [MASS_W-1:0] div_divisor;
  logic [TOT_W-1:0]  div_quotient;

  modport master (
    input  div_rfd,
    input  div_quotient,
    output div_nd,
    output div_dividend,
    output div_divisor
  );

  modport slave (
    output div_rfd,
    output div_quotient,
    input  div_nd,
    input  div_dividend,
    input  div_divisor
  );

endinterface

// File: rtl/com_divide_scheduler_clamp.sv
// Saturates a full-width quotient to a 10-bit screen coordinate.
// Compares on all quotient bits so large values never wrap.
module com_clamp
  import com_divide_scheduler_pkg::*;
(
  input  logic [TOT_W-1:0] q_i,
  input  logic [CEN_W-1:0] bound_i,
  output logic [CEN_W-1:0] val_o
);

  logic over;

  assign over  = q_i > TOT_W'(bound_i);
  assign val_o = over ? bound_i : q_i[CEN_W-1:0];

endmodule

// File: rtl/com_divide_scheduler.sv
// Time-multiplexes the X and Y centre divisions through one divider
// and publishes both clamped centres together once per frame.
module com_divide_scheduler
  import com_divide_scheduler_pkg::*;
#(
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int MIN_MASS    = DEF_MIN_MASS,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic [TOT_W-1:0]     x_total,
  input  logic [TOT_W-1:0]     y_total,
  input  logic [MASS_W-1:0]    mass_total,
  com_divide_scheduler_if.master div,
  output logic [CEN_W-1:0]     x_center,
  output logic [CEN_W-1:0]     y_center,
  output logic                 center_valid,
  output logic                 target_lost,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CEN_W-1:0] XB = CEN_W'(X_MAX);
  localparam logic [CEN_W-1:0] YB = CEN_W'(Y_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOT_W-1:0]  xt_q, xt_d;
  logic [TOT_W-1:0]  yt_q, yt_d;
  logic [MASS_W-1:0] m_q, m_d;
  logic [CEN_W-1:0]  xh_q, xh_d;
  logic [CEN_W-1:0]  xc_q, xc_d;
  logic [CEN_W-1:0]  yc_q, yc_d;
  logic              cv_q, cv_d;
  logic              tl_q, tl_d;
  logic              ov_q, ov_d;

  logic              nd;
  logic [TOT_W-1:0]  dividend;
  logic [MASS_W-1:0] divisor;
  logic [CEN_W-1:0]  x_cl;
  logic [CEN_W-1:0]  y_cl;
  logic              light;

  com_clamp u_clamp_x (
    .q_i     (div.div_quotient),
    .bound_i (XB),
    .val_o   (x_cl)
  );

  com_clamp u_clamp_y (
    .q_i     (div.div_quotient),
    .bound_i (YB),
    .val_o   (y_cl)
  );

  assign light = mass_total < MASS_W'(MIN_MASS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xt_d     = xt_q;
    yt_d     = yt_q;
    m_d      = m_q;
    xh_d     = xh_q;
    xc_d     = xc_q;
    yc_d     = yc_q;
    cv_d     = 1'b0;
    tl_d     = tl_q;
    // a frame arriving outside IDLE is dropped, never queued
    ov_d     = ov_q | (frame_done & (state_q != S_IDLE));
    nd       = 1'b0;
    dividend = '0;
    divisor  = MASS_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (frame_done) begin
          xt_d = x_total;
          yt_d = y_total;
          m_d  = mass_total;
          if (light) begin
            tl_d = 1'b1;
            cv_d = 1'b1;
          end else begin
            tl_d    = 1'b0;
            state_d = S_ISSUE_X;
          end
        end
      end
      S_ISSUE_X: begin
        dividend = xt_q;
        divisor  = m_q;
        nd       = div.div_rfd;
        if (div.div_rfd) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT_X;
        end
      end
      S_WAIT_X: begin
        if (cnt_q == '0) begin
          xh_d    = x_cl;
          state_d = S_ISSUE_Y;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ISSUE_Y: begin
        dividend = yt_q;
        divisor  = m_q;
        nd       = div.div_rfd;
        if (div.div_rfd) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT_Y;
        end
      end
      S_WAIT_Y: begin
        if (cnt_q == '0) begin
          xc_d    = xh_q;
          yc_d    = y_cl;
          cv_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xt_q    <= '0;
      yt_q    <= '0;
      m_q     <= '0;
      xh_q    <= '0;
      xc_q    <= mid_of(X_MAX);
      yc_q    <= mid_of(Y_MAX);
      cv_q    <= 1'b0;
      tl_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xt_q    <= xt_d;
      yt_q    <= yt_d;
      m_q     <= m_d;
      xh_q    <= xh_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      cv_q    <= cv_d;
      tl_q    <= tl_d;
      ov_q    <= ov_d;
    end
  end

  assign div.div_nd       = nd;
  assign div.div_dividend = dividend;
  assign div.div_divisor  = divisor;

  assign x_center     = xc_q;
  assign y_center     = yc_q;
  assign center_valid = cv_q;
  assign target_lost  = tl_q;
  assign busy         = state_q != S_IDLE;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_com_divide_scheduler.sv
// Randomised bench for com_divide_scheduler with a fake 4-cycle divider
// and an arithmetic reference model of the published centres.
module tb_com_divide_scheduler;
  import com_divide_scheduler_pkg::*;

  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_done = 1'b0;
  logic [TOT_W-1:0]  x_total = '0;
  logic [TOT_W-1:0]  y_total = '0;
  logic [MASS_W-1:0] mass_total = '0;
  logic [CEN_W-1:0]  x_center;
  logic [CEN_W-1:0]  y_center;
  logic              center_valid;
  logic              target_lost;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int failures = 0;

  longint ex_x = 319;
  longint ex_y = 239;
  longint opq_dd[$];
  longint opq_dv[$];
  int     nd_bad = 0;

  com_divide_scheduler_if div_if();

  com_divide_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_done   (frame_done),
    .x_total      (x_total),
    .y_total      (y_total),
    .mass_total   (mass_total),
    .div          (div_if),
    .x_center     (x_center),
    .y_center     (y_center),
    .center_valid (center_valid),
    .target_lost  (target_lost),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // fake divider: all-ones marks "no valid result" so mistimed captures clamp
  logic [TOT_W-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (div_if.div_nd && div_if.div_rfd && div_if.div_divisor != '0)
      pipe[0] <= div_if.div_dividend / TOT_W'(div_if.div_divisor);
    else
      pipe[0] <= '1;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign div_if.div_quotient = pipe[LAT-1];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(longint t, longint m, longint mx);
    longint q;
    q = t / m;
    return (q > mx) ? mx : q;
  endfunction

  task automatic cyc();
    @(negedge clk);
    if (div_if.div_nd) begin
      if (!div_if.div_rfd) nd_bad++;
      opq_dd.push_back(longint'(div_if.div_dividend));
      opq_dv.push_back(longint'(div_if.div_divisor));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(longint x, longint y, longint m,
                           int stall_y, int ov_at);
    int e;
    bit seen;
    opq_dd.delete();
    opq_dv.delete();
    nd_bad = 0;
    frame_done = 1'b1;
    x_total    = TOT_W'(x);
    y_total    = TOT_W'(y);
    mass_total = MASS_W'(m);
    cyc();
    frame_done = 1'b0;
    x_total    = TOT_W'($urandom);
    y_total    = TOT_W'($urandom);
    mass_total = MASS_W'($urandom);
    chk("busy_start", 64'(busy), 64'd1);
    e = 0;
    seen = 1'b0;
    while (!seen && e < 100) begin
      if (e == 5 && stall_y > 0) div_if.div_rfd = 1'b0;
      if (e == 5 + stall_y) div_if.div_rfd = 1'b1;
      frame_done = (e == ov_at);
      cyc();
      e++;
      if (center_valid) seen = 1'b1;
    end
    frame_done = 1'b0;
    div_if.div_rfd = 1'b1;
    ex_x = clampv(x, m, 639);
    ex_y = clampv(y, m, 479);
    chk("cv_seen", 64'(seen), 64'd1);
    chk("latency", 64'(e), 64'(2 * LAT + 2 + stall_y));
    chk("x_center", 64'(x_center), ex_x);
    chk("y_center", 64'(y_center), ex_y);
    chk("tgt_lost", 64'(target_lost), 64'd0);
    chk("nd_count", 64'(opq_dd.size()), 64'd2);
    chk("nd_no_rfd", 64'(nd_bad), 64'd0);
    if (opq_dd.size() == 2) begin
      chk("op_x_dd", opq_dd[0], x);
      chk("op_x_dv", opq_dv[0], m);
      chk("op_y_dd", opq_dd[1], y);
      chk("op_y_dv", opq_dv[1], m);
    end
    if (ov_at >= 0) chk("overrun", 64'(overrun), 64'd1);
    cyc();
    chk("cv_pulse", 64'(center_valid), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  task automatic lost_frame(longint m);
    opq_dd.delete();
    opq_dv.delete();
    frame_done = 1'b1;
    x_total    = TOT_W'($urandom);
    y_total    = TOT_W'($urandom);
    mass_total = MASS_W'(m);
    cyc();
    frame_done = 1'b0;
    chk("lost_cv", 64'(center_valid), 64'd1);
    chk("lost_tl", 64'(target_lost), 64'd1);
    chk("lost_busy", 64'(busy), 64'd0);
    repeat (12) cyc();
    chk("lost_nd", 64'(opq_dd.size()), 64'd0);
    chk("lost_tl_hold", 64'(target_lost), 64'd1);
    chk("lost_x", 64'(x_center), ex_x);
    chk("lost_y", 64'(y_center), ex_y);
  endtask

  initial begin
    int cvs;
    longint m;
    longint x;
    longint y;
    div_if.div_rfd = 1'b1;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (20) cyc();
    chk("rst_x", 64'(x_center), 64'd319);
    chk("rst_y", 64'(y_center), 64'd239);
    chk("rst_cv", 64'(center_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_tl", 64'(target_lost), 64'd0);
    chk("rst_dd", 64'(div_if.div_dividend), 64'd0);
    chk("rst_dv", 64'(div_if.div_divisor), 64'd1);
    chk("rst_nd", 64'(opq_dd.size()), 64'd0);

    run_frame(32000, 24000, 100, 0, -1);
    lost_frame(10);
    run_frame(90000, 24000, 100, 0, -1);
    run_frame(32000, 24000, 100, 7, -1);
    run_frame(639 * 64 + 63, 479 * 64 + 63, 64, 0, -1);
    run_frame(640 * 64, 480 * 64, 64, 0, -1);
    run_frame(1024 * 100 + 5, 1024 * 100, 100, 0, -1);
    lost_frame(63);
    lost_frame(0);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: lost_frame(longint'($urandom_range(0, 63)));
        1: begin
          m = longint'($urandom_range(64, 67108863));
          x = longint'({$urandom, $urandom}) & 64'h7_FFFF_FFFF;
          y = longint'({$urandom, $urandom}) & 64'h7_FFFF_FFFF;
          run_frame(x, y, m, int'($urandom_range(0, 5)), -1);
        end
        default: begin
          m = longint'($urandom_range(64, 5000));
          x = longint'($urandom_range(0, 700)) * m
            + longint'($urandom_range(0, 63));
          y = longint'($urandom_range(0, 520)) * m
            + longint'($urandom_range(0, 63));
          run_frame(x, y, m, int'($urandom_range(0, 5)), -1);
        end
      endcase
    end

    run_frame(12345, 6789, 77, 0, 2);
    run_frame(50000, 30000, 200, 0, -1);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    run_frame(40000, 20000, 150, 0, 9);

    opq_dd.delete();
    opq_dv.delete();
    frame_done = 1'b1;
    x_total    = TOT_W'(32000);
    y_total    = TOT_W'(24000);
    mass_total = MASS_W'(100);
    cyc();
    frame_done = 1'b0;
    repeat (7) cyc();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    opq_dd.delete();
    ex_x = 319;
    ex_y = 239;
    chk("mid_rst_x", 64'(x_center), ex_x);
    chk("mid_rst_y", 64'(y_center), ex_y);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ovr", 64'(overrun), 64'd0);
    chk("mid_rst_tl", 64'(target_lost), 64'd0);
    cvs = 0;
    repeat (25) begin
      cyc();
      if (center_valid) cvs++;
    end
    chk("stale_cv", 64'(cvs), 64'd0);
    chk("stale_nd", 64'(opq_dd.size()), 64'd0);
    chk("stale_x", 64'(x_center), ex_x);
    chk("stale_y", 64'(y_center), ex_y);

    run_frame(32000, 24000, 100, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
